// File: rtl/counter_pkg.sv
// Shared constants for the counter bank: per-channel counting mode encodings.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_FREE = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int MODE_W = 2;

endpackage

// File: rtl/counter_chan.sv
// One counter channel: clear/load/inc/dec with wrap, saturate or free-running
// behaviour, a one-cycle terminal-count pulse and a sticky overflow flag.
module counter_chan
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic [WIDTH-1:0]  max_val_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              ovf_clr_i,
    output logic [WIDTH-1:0]  cnt_o,
    output logic              eq_o,
    output logic              tc_o,
    output logic              ovf_o
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    mode_e            mode;
    logic [WIDTH-1:0] limit;
    logic             at_top;
    logic             at_zero;
    logic             wrap_evt;

    always_comb begin
        mode     = mode_e'(mode_i);
        // FREE counts through the full range regardless of max_val
        limit    = (mode == MODE_FREE) ? ALL_ONES : max_val_i;
        at_top   = (cnt_q >= limit);
        at_zero  = (cnt_q == ZERO);

        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        wrap_evt = 1'b0;

        if (clr_i) begin
            cnt_d = ZERO;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            if (!at_top) begin
                cnt_d = cnt_q + ONE;
            end else if (mode == MODE_SAT) begin
                tc_d = 1'b1;
            end else begin
                cnt_d    = ZERO;
                tc_d     = 1'b1;
                wrap_evt = 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (!at_zero) begin
                cnt_d = cnt_q - ONE;
            end else if (mode == MODE_SAT) begin
                tc_d = 1'b1;
            end else begin
                cnt_d    = limit;
                tc_d     = 1'b1;
                wrap_evt = 1'b1;
            end
        end

        // a wrap in the same cycle as ovf_clr wins; clr always wins
        if (clr_i) begin
            ovf_d = 1'b0;
        end else if (wrap_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign eq_o  = (cnt_q == max_val_i);
    assign tc_o  = tc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent counter channels; this level only slices the packed
// buses into per-channel fields.
module counter_bank
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       dec,
    input  logic [NCH*WIDTH-1:0] max_val,
    input  logic [NCH*2-1:0]     mode,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       eq,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       ovf
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (clr[g]),
            .load_i     (load[g]),
            .load_val_i (load_val[g*WIDTH +: WIDTH]),
            .inc_i      (inc[g]),
            .dec_i      (dec[g]),
            .max_val_i  (max_val[g*WIDTH +: WIDTH]),
            .mode_i     (mode[g*MODE_W +: MODE_W]),
            .ovf_clr_i  (ovf_clr[g]),
            .cnt_o      (cnt[g*WIDTH +: WIDTH]),
            .eq_o       (eq[g]),
            .tc_o       (tc[g]),
            .ovf_o      (ovf[g])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: directed scenarios plus randomized traffic, all
// checked against an arithmetic per-channel reference model.
module tb_counter_bank;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int TOPV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     clr, load, inc, dec, ovf_clr;
    logic [N*W-1:0]   load_val, max_val, cnt;
    logic [N*2-1:0]   mode;
    logic [N-1:0]     eq, tc, ovf;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt [N];
    int m_tc  [N];
    int m_ovf [N];

    counter_bank #(.WIDTH(W), .NCH(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .inc      (inc),
        .dec      (dec),
        .max_val  (max_val),
        .mode     (mode),
        .ovf_clr  (ovf_clr),
        .cnt      (cnt),
        .eq       (eq),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
            m_ovf[i] = 0;
        end
    endtask

    // Next-state of every channel from the rules: priority clr > load > inc^dec,
    // WRAP/mode3 wrap at max_val, SAT holds at the limits, FREE wraps at 2^W.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int c, mx, md, lim, t, wr;
            c   = m_cnt[i];
            mx  = int'(max_val[i*W +: W]);
            md  = int'(mode[i*2 +: 2]);
            lim = (md == 2) ? TOPV : mx;
            t   = 0;
            wr  = 0;
            if (clr[i]) begin
                c = 0;
            end else if (load[i]) begin
                c = int'(load_val[i*W +: W]);
            end else if (inc[i] && !dec[i]) begin
                if (md == 1) begin
                    if (c >= mx) t = 1; else c = c + 1;
                end else if (c >= lim) begin
                    c = 0; wr = 1;
                end else begin
                    c = c + 1;
                end
            end else if (dec[i] && !inc[i]) begin
                if (c == 0) begin
                    if (md == 1) t = 1;
                    else begin c = lim; wr = 1; end
                end else begin
                    c = c - 1;
                end
            end
            if (wr) t = 1;
            if (clr[i])          m_ovf[i] = 0;
            else if (wr)         m_ovf[i] = 1;
            else if (ovf_clr[i]) m_ovf[i] = 0;
            m_cnt[i] = c;
            m_tc[i]  = t;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.cnt%0d", tag, i), 32'(cnt[i*W +: W]), 32'(m_cnt[i]));
            chk($sformatf("%s.tc%0d",  tag, i), 32'(tc[i]),  32'(m_tc[i]));
            chk($sformatf("%s.ovf%0d", tag, i), 32'(ovf[i]), 32'(m_ovf[i]));
            chk($sformatf("%s.eq%0d",  tag, i), 32'(eq[i]),
                32'(m_cnt[i] == int'(max_val[i*W +: W])));
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_reqs();
        clr = '0; load = '0; inc = '0; dec = '0; ovf_clr = '0;
    endtask

    initial begin
        int e33_cnt [7] = '{1, 2, 3, 4, 5, 0, 1};
        int e33_tc  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int e33_ovf [7] = '{0, 0, 0, 0, 0, 1, 1};
        int e34_cnt [6] = '{1, 2, 3, 3, 3, 3};
        int e34_tc  [6] = '{0, 0, 0, 1, 1, 1};
        int e35_cnt [3] = '{8'hFF, 8'h00, 8'h01};
        int e35_tc  [3] = '{0, 1, 0};
        int e35_ovf [3] = '{0, 1, 1};

        rst_n = 1'b0;
        clear_reqs();
        load_val = '0;
        max_val  = '0;
        mode     = '0;
        max_val[7:0] = 8'd5;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.eq0", 32'(eq[0]), 32'd0);
        chk("reset.eq1", 32'(eq[1]), 32'd1);
        rst_n = 1'b1;
        cycle("idle");

        // WRAP at max_val=5
        mode[1:0] = 2'd0;
        inc[0]    = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle("wrap");
            chk("wrap.cnt", 32'(cnt[7:0]), 32'(e33_cnt[k]));
            chk("wrap.tc",  32'(tc[0]),    32'(e33_tc[k]));
            chk("wrap.ovf", 32'(ovf[0]),   32'(e33_ovf[k]));
            chk("wrap.eq",  32'(eq[0]),    32'(e33_cnt[k] == 5));
        end
        inc[0] = 1'b0;

        // SAT at max_val=3
        clr[0] = 1'b1;
        cycle("sat_clr");
        clr[0] = 1'b0;
        mode[1:0]    = 2'd1;
        max_val[7:0] = 8'd3;
        inc[0]       = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle("sat");
            chk("sat.cnt", 32'(cnt[7:0]), 32'(e34_cnt[k]));
            chk("sat.tc",  32'(tc[0]),    32'(e34_tc[k]));
            chk("sat.ovf", 32'(ovf[0]),   32'd0);
        end
        inc[0] = 1'b0;
        clr[0] = 1'b1;
        cycle("sat_clr2");
        clr[0] = 1'b0;
        dec[0] = 1'b1;
        cycle("sat_dec0");
        chk("sat_dec0.cnt", 32'(cnt[7:0]), 32'd0);
        chk("sat_dec0.tc",  32'(tc[0]),    32'd1);
        dec[0] = 1'b0;

        // FREE across the 2^W boundary
        mode[1:0]     = 2'd2;
        load[0]       = 1'b1;
        load_val[7:0] = 8'hFE;
        cycle("free_load");
        load[0] = 1'b0;
        inc[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("free");
            chk("free.cnt", 32'(cnt[7:0]), 32'(e35_cnt[k]));
            chk("free.tc",  32'(tc[0]),    32'(e35_tc[k]));
            chk("free.ovf", 32'(ovf[0]),   32'(e35_ovf[k]));
        end
        inc[0]     = 1'b0;
        ovf_clr[0] = 1'b1;
        cycle("free_ovfclr");
        chk("free_ovfclr.ovf", 32'(ovf[0]), 32'd0);
        ovf_clr[0] = 1'b0;
        clr[0]     = 1'b1;
        cycle("free_clr");
        clr[0] = 1'b0;
        dec[0] = 1'b1;
        cycle("free_dec");
        chk("free_dec.cnt", 32'(cnt[7:0]), 32'hFF);
        chk("free_dec.ovf", 32'(ovf[0]),   32'd1);
        dec[0] = 1'b0;

        // priority clr > load > inc; inc+dec holds
        load[0]       = 1'b1;
        load_val[7:0] = 8'd7;
        cycle("prio_load7");
        clr[0]        = 1'b1;
        load_val[7:0] = 8'h10;
        inc[0]        = 1'b1;
        cycle("prio_clr");
        chk("prio_clr.cnt", 32'(cnt[7:0]), 32'd0);
        chk("prio_clr.ovf", 32'(ovf[0]),   32'd0);
        clr[0] = 1'b0;
        cycle("prio_load");
        chk("prio_load.cnt", 32'(cnt[7:0]), 32'h10);
        load[0] = 1'b0;
        dec[0]  = 1'b1;
        cycle("prio_incdec");
        chk("prio_incdec.cnt", 32'(cnt[7:0]), 32'h10);
        clear_reqs();

        // concurrent random traffic, one mode per channel
        mode = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int k = 0; k < 400; k++) begin
            if (k % 64 == 0)
                for (int i = 0; i < N; i++)
                    max_val[i*W +: W] = W'($urandom_range(0, TOPV));
            for (int i = 0; i < N; i++) begin
                inc[i]     = 1'($urandom_range(0, 1));
                dec[i]     = 1'($urandom_range(0, 1));
                load[i]    = ($urandom_range(0, 15) == 0);
                clr[i]     = ($urandom_range(0, 31) == 0);
                ovf_clr[i] = ($urandom_range(0, 15) == 0);
                load_val[i*W +: W] = W'($urandom_range(0, TOPV));
            end
            cycle("rand");
        end
        clear_reqs();

        // async reset mid-count
        mode          = '0;
        max_val[7:0]  = 8'd10;
        load[0]       = 1'b1;
        load_val[7:0] = 8'd4;
        cycle("rst_load");
        load[0] = 1'b0;
        inc[0]  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid.cnt0", 32'(cnt[7:0]), 32'd0);
        #2;
        rst_n = 1'b1;
        cycle("resume");
        chk("resume.cnt0", 32'(cnt[7:0]), 32'd1);
        clear_reqs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per channel counter.
REQ-002 SHALL have parameter NCH, default 4, meaning number of independent channels (1..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  NCH  per-channel synchronous clear.
REQ-006 SHALL have port load  input  NCH  per-channel synchronous load.
REQ-007 SHALL have port load_val  input  NCH*WIDTH  load values; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port inc  input  NCH  per-channel increment request.
REQ-009 SHALL have port dec  input  NCH  per-channel decrement request.
REQ-010 SHALL have port max_val  input  NCH*WIDTH  per-channel terminal value, packed as load_val.
REQ-011 SHALL have port mode  input  NCH*2  per-channel mode: 0 WRAP, 1 SAT, 2 FREE, 3 treated as WRAP.
REQ-012 SHALL have port ovf_clr  input  NCH  per-channel clear of the sticky overflow flag.
REQ-013 SHALL have port cnt  output  NCH*WIDTH  registered channel counts.
REQ-014 SHALL have port eq  output  NCH  combinational, eq[i] = (cnt_i == max_val_i).
REQ-015 SHALL have port tc  output  NCH  registered one-cycle terminal-count pulse.
REQ-016 SHALL have port ovf  output  NCH  registered sticky overflow/underflow flag.

Function
REQ-017 Per-channel priority SHALL be clr > load > (inc XOR dec); inc and dec together SHALL hold the count.
REQ-018 clr SHALL set cnt to 0 and ovf to 0 on the next edge; load SHALL set cnt to load_val, ovf unchanged.
REQ-019 Effect of a request SHALL be visible on cnt one cycle after the sampling edge; no other latency.
REQ-020 WRAP inc with cnt >= max_val SHALL give 0; WRAP dec with cnt == 0 SHALL give max_val; both are wrap events.
REQ-021 SAT inc with cnt >= max_val SHALL hold max_val (or hold a loaded value above it); SAT dec at 0 SHALL hold 0; both are saturation events.
REQ-022 FREE SHALL ignore max_val for counting and wrap modulo 2^WIDTH; all-ones->0 on inc and 0->all-ones on dec are wrap events.
REQ-023 tc[i] SHALL be 1 exactly in the cycle after a wrap or saturation event, else 0; repeated SAT requests at a limit SHALL pulse every cycle.
REQ-024 ovf[i] SHALL set on any wrap event (not saturation) and hold until clr[i] or ovf_clr[i]; a same-cycle set and ovf_clr SHALL leave ovf at 1.
REQ-025 A mode change SHALL take effect on the next request; cnt SHALL NOT be modified by the mode change itself.
REQ-026 Channels SHALL be fully independent; no cross-channel interaction.
REQ-027 All arithmetic SHALL be WIDTH bits unsigned; comparisons SHALL be unsigned.

Reset
REQ-028 rst_n low SHALL asynchronously force cnt=0, tc=0, ovf=0 on all channels.
REQ-029 Reset assertion mid-count SHALL discard in-flight requests; first update after deassertion SHALL use inputs sampled at the first rising edge with rst_n high.
REQ-030 eq SHALL reflect 0 == max_val_i during reset.

Structure
REQ-031 Mode encodings (WRAP, SAT, FREE) SHALL be constants in shared package counter_pkg.
REQ-032 Per-channel logic SHALL be sub-module counter_chan (WIDTH parameter), instantiated NCH times by a generate loop; counter_bank SHALL contain only packing/unpacking.

Verification
REQ-033 WIDTH=8, mode WRAP, max_val=5, inc held 7 cycles from 0 -> cnt 1,2,3,4,5,0,1; tc and ovf rise the cycle cnt shows 0; eq high while cnt=5.
REQ-034 mode SAT, max_val=3, inc held 6 cycles -> cnt sticks at 3; tc high each cycle after cnt reached 3 with inc still asserted; ovf stays 0; dec at 0 -> cnt 0, tc pulses.
REQ-035 mode FREE, load 0xFE, then inc x3 -> 0xFF,0x00,0x01; ovf set at 0x00; ovf_clr pulse -> ovf 0; dec from 0 -> 0xFF, ovf 1.
REQ-036 clr, load=0x10 and inc in same cycle with cnt=7 -> cnt 0, ovf 0; next load+inc -> cnt 0x10; inc+dec together -> cnt unchanged.
REQ-037 NCH=4, channel 0 WRAP, 1 SAT, 2 FREE, 3 mode=3 driven concurrently with random inc/dec/load -> each matches a per-channel reference model; no cross-talk.
REQ-038 rst_n pulsed low between edges while cnt=4 and inc high -> cnt, tc, ovf 0 immediately; count resumes 1 at first edge after release.
